// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU core
// (default owner) and a secondary DMA master. The CPU is stalled via cpu_rdy
// only while DMA actually owns the RAM. A run counter forces DMA in after
// MAX_CPU_RUN CPU cycles with DMA pending, and a burst counter caps
// consecutive DMA grants at DMA_MAX_BURST.
//
// Ports:
//   sys_clk, sys_rst_n              clock (rising edge), async active-low reset
//   cpu_addr/cpu_we/cpu_dout        CPU request (AB/WE/DO)
//   cpu_din, cpu_rdy                CPU read data (DI) and RDY (0 = stall)
//   dma_req/dma_addr/dma_we/dma_wdata  DMA request, held until granted
//   dma_gnt                         DMA request issued to RAM this cycle
//   dma_rdata, dma_rvalid           DMA read data and its one-cycle valid
//   mem_addr/mem_we/mem_wdata       RAM request
//   mem_rdata                       RAM read data, one cycle after address
module mem_arbiter #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned MAX_CPU_RUN   = 4,
    parameter int unsigned DMA_MAX_BURST = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned RUN_W   = (MAX_CPU_RUN > 1)   ? $clog2(MAX_CPU_RUN)   : 1;
    localparam int unsigned BURST_W = (DMA_MAX_BURST > 1) ? $clog2(DMA_MAX_BURST) : 1;
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(MAX_CPU_RUN - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_MAX_BURST - 1);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_t;

    state_t              state;
    logic [RUN_W-1:0]    run_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic                rd_dma_q;
    logic [DATA_W-1:0]   cpu_hold;
    logic                dma_own;

    // DMA owns the RAM only while in DMA state and still requesting, so a
    // dropped request hands the current cycle straight back to the CPU.
    assign dma_own = (state == ST_DMA) && dma_req;

    // RAM request mux
    assign mem_addr  = dma_own ? dma_addr  : cpu_addr;
    assign mem_we    = dma_own ? dma_we    : cpu_we;
    assign mem_wdata = dma_own ? dma_wdata : cpu_dout;

    assign dma_gnt    = dma_own;
    assign cpu_rdy    = ~dma_own;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = rd_dma_q;

    // In the DMA return cycle mem_rdata belongs to DMA; show the CPU its
    // last own read value instead so DI stays stable across the stall.
    assign cpu_din = rd_dma_q ? cpu_hold : mem_rdata;

    // Ownership FSM with fairness and burst counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_CPU;
            run_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_CPU: begin
                    if (!dma_req) begin
                        run_cnt <= '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state     <= ST_DMA;
                        burst_cnt <= '0;
                        run_cnt   <= '0;
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end
                ST_DMA: begin
                    if (!dma_req || (burst_cnt == BURST_LAST)) begin
                        state <= ST_CPU;
                    end else begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
                default: state <= ST_CPU;
            endcase
        end
    end

    // Read-return tracking and CPU read-data hold
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_dma_q <= 1'b0;
            cpu_hold <= '0;
        end else begin
            rd_dma_q <= dma_own & ~dma_we;
            if (!rd_dma_q) begin
                cpu_hold <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a
// behavioural single-port synchronous RAM (read-first, one-cycle latency).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_rdy;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_we;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(4), .DMA_MAX_BURST(2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_we    (dma_we),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // RAM model with a bench-side preload port
    always @(posedge sys_clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic req;
        logic exp_gnt;
        logic exp_rdy;
        logic exp_rvalid;
    } vec_t;

    vec_t vecs [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_addr  = 16'h1000;
        cpu_we    = 1'b0;
        cpu_dout  = 8'h00;
        dma_req   = 1'b0;
        dma_addr  = 16'h2000;
        dma_we    = 1'b0;
        dma_wdata = 8'h00;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 after release
    task automatic do_reset();
        sys_rst_n = 1'b0;
        idle_inputs();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic apply_row(input int i);
        logic [ADDR_W-1:0] exp_addr;
        dma_req = vecs[i].req;
        #3;
        exp_addr = vecs[i].exp_gnt ? 16'h2000 : 16'h1000;
        chk($sformatf("row%0d_gnt", i),    32'(dma_gnt),    32'(vecs[i].exp_gnt));
        chk($sformatf("row%0d_rdy", i),    32'(cpu_rdy),    32'(vecs[i].exp_rdy));
        chk($sformatf("row%0d_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].exp_rvalid));
        chk($sformatf("row%0d_addr", i),   32'(mem_addr),   32'(exp_addr));
    endtask

    initial begin
        int cyc;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        sys_rst_n = 1'b0;
        idle_inputs();

        // Fairness: req held from cycle 0; grants in 4,5,10,11,16,17
        for (int i = 0; i < 18; i++) begin
            vecs[i].req        = 1'b1;
            vecs[i].exp_gnt    = (i == 4) || (i == 5) || (i == 10) || (i == 11) ||
                                 (i == 16) || (i == 17);
            vecs[i].exp_rdy    = ~vecs[i].exp_gnt;
            vecs[i].exp_rvalid = (i == 5) || (i == 6) || (i == 11) || (i == 12) ||
                                 (i == 17);
        end
        // Run reset: req 1,1,0 then held; first grant at cycle 7
        for (int i = 0; i < 9; i++) begin
            vecs[18+i].req        = (i != 2);
            vecs[18+i].exp_gnt    = (i == 7) || (i == 8);
            vecs[18+i].exp_rdy    = ~vecs[18+i].exp_gnt;
            vecs[18+i].exp_rvalid = (i == 8);
        end

        // Reset state, then RAM preload while still in reset
        #3;
        chk("rst_rdy",    32'(cpu_rdy),    32'd1);
        chk("rst_gnt",    32'(dma_gnt),    32'd0);
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_addr",   32'(mem_addr),   32'h1000);
        preload(16'h0010, 8'hA5);
        preload(16'h0200, 8'h3C);
        preload(16'h0300, 8'h00);

        // Fairness table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) tick();
            apply_row(i);
        end

        // Async reset mid-burst (cycle 17, second burst beat)
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_rdy",    32'(cpu_rdy),    32'd1);
        chk("midrst_gnt",    32'(dma_gnt),    32'd0);
        chk("midrst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("midrst_addr",   32'(mem_addr),   32'h1000);
        dma_req = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        cpu_addr  = 16'h0010;
        #3;
        chk("postrst_addr", 32'(mem_addr), 32'h0010);
        chk("postrst_rdy",  32'(cpu_rdy),  32'd1);
        tick();
        #3;
        chk("postrst_din",  32'(cpu_din),  32'hA5);

        // Run-reset table
        do_reset();
        for (int i = 18; i < 27; i++) begin
            if (i > 18) tick();
            apply_row(i);
        end

        // DMA read of 0x0200 while the CPU reads 0x0010
        do_reset();
        cpu_addr = 16'h0010;
        #3;
        tick();
        dma_req  = 1'b1;
        dma_addr = 16'h0200;
        dma_we   = 1'b0;
        #3;
        chk("rd_cpu_din_pre", 32'(cpu_din), 32'hA5);
        cyc = 1;
        while (dma_gnt !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
            #3;
        end
        chk("rd_gnt",     32'(dma_gnt), 32'd1);
        chk("rd_latency", 32'(cyc),     32'd5);
        tick();
        dma_req = 1'b0;
        #3;
        chk("rd_rvalid",   32'(dma_rvalid), 32'd1);
        chk("rd_rdata",    32'(dma_rdata),  32'h3C);
        chk("rd_cpu_hold", 32'(cpu_din),    32'hA5);
        chk("rd_rdy",      32'(cpu_rdy),    32'd1);
        tick();
        #3;
        chk("rd_rvalid_off", 32'(dma_rvalid), 32'd0);
        chk("rd_cpu_din",    32'(cpu_din),    32'hA5);

        // DMA write / CPU write collision on 0x0300
        do_reset();
        cpu_addr  = 16'h0040;
        dma_req   = 1'b1;
        dma_addr  = 16'h0300;
        dma_we    = 1'b1;
        dma_wdata = 8'h22;
        repeat (4) tick();
        cpu_addr = 16'h0300;
        cpu_we   = 1'b1;
        cpu_dout = 8'h11;
        #3;
        chk("col_gnt",   32'(dma_gnt),   32'd1);
        chk("col_rdy",   32'(cpu_rdy),   32'd0);
        chk("col_we",    32'(mem_we),    32'd1);
        chk("col_wdata", 32'(mem_wdata), 32'h22);
        tick();
        dma_req = 1'b0;
        #3;
        chk("col_ram_dma",  32'(ram[16'h0300]), 32'h22);
        chk("col_rdy2",     32'(cpu_rdy),       32'd1);
        chk("col_cpu_data", 32'(mem_wdata),     32'h11);
        chk("col_cpu_we",   32'(mem_we),        32'd1);
        chk("col_norvalid", 32'(dma_rvalid),    32'd0);
        tick();
        cpu_we = 1'b0;
        #3;
        chk("col_ram_final", 32'(ram[16'h0300]), 32'h11);
        tick();
        #3;
        chk("col_cpu_rd", 32'(cpu_din), 32'h11);

        // Early release after 1 of 2 burst beats
        do_reset();
        cpu_addr = 16'h1234;
        dma_req  = 1'b1;
        dma_addr = 16'h2000;
        repeat (4) tick();
        #3;
        chk("er_gnt",  32'(dma_gnt),  32'd1);
        chk("er_addr", 32'(mem_addr), 32'h2000);
        tick();
        dma_req = 1'b0;
        #3;
        chk("er_rdy",    32'(cpu_rdy),    32'd1);
        chk("er_gnt0",   32'(dma_gnt),    32'd0);
        chk("er_addr2",  32'(mem_addr),   32'h1234);
        chk("er_rvalid", 32'(dma_rvalid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
